// File: rtl/avalon_pio_in_edge_pkg.sv
// pio_in_pkg: register addresses and edge-type codes shared by avalon_pio_in_edge and its bench
package pio_in_pkg;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/avalon_pio_in_edge_if.sv
// avalon_pio_in_edge_if: Avalon-MM slave bus plus level interrupt for the input PIO
interface avalon_pio_in_edge_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  modport master(output address, chipselect, write_n, writedata, input readdata, irq);
  modport slave(input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/avalon_pio_in_edge_debounce.sv
// pio_debounce_bit: per-bit debouncer; filt follows sync only after it differs for DEBOUNCE_CYCLES+1 clocks
module pio_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync,
  output logic filt
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (sync == filt) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
      filt <= sync;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/avalon_pio_in_edge.sv
// avalon_pio_in_edge: Avalon-MM input PIO with synchroniser, edge capture and maskable level irq
// Optional debounce filter compiled in with macro PIO_DEBOUNCE_EN.
module avalon_pio_in_edge
  import pio_in_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  avalon_pio_in_edge_if.slave  bus,
  input  logic [WIDTH-1:0]     in_port
);
  if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 || EDGE_TYPE < 0 || EDGE_TYPE > 2 ||
      DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_cfg
    $error("avalon_pio_in_edge: parameter out of range");
  end
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync, filt, prev, rise, fall, edge_hit, clr, edgecapture, irqmask, rd_mux;
  logic wr;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
  assign sync = sync_q[SYNC_STAGES-1];
`ifdef PIO_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    pio_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .reset_n(reset_n), .sync(sync[i]), .filt(filt[i])
    );
  end
`else
  assign filt = sync;
`endif
  assign rise     = filt & ~prev;
  assign fall     = ~filt & prev;
  assign edge_hit = EDGE_TYPE == EDGE_RISE ? rise : EDGE_TYPE == EDGE_FALL ? fall : rise | fall;
  assign wr       = bus.chipselect & ~bus.write_n;
  assign clr      = wr && bus.address == ADDR_EDGE ? bus.writedata[WIDTH-1:0] : '0;
  assign rd_mux   = bus.address == ADDR_DATA ? filt :
                    bus.address == ADDR_MASK ? irqmask :
                    bus.address == ADDR_EDGE ? edgecapture : '0;
  assign bus.irq  = |(edgecapture & irqmask);
  // a fresh edge is ORed in after the clear so a same-cycle set survives the W1C
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      prev         <= '0;
      edgecapture  <= '0;
      irqmask      <= '0;
      bus.readdata <= '0;
    end else begin
      prev         <= filt;
      edgecapture  <= (edgecapture & ~clr) | edge_hit;
      if (wr && bus.address == ADDR_MASK) irqmask <= bus.writedata[WIDTH-1:0];
      bus.readdata <= 32'(rd_mux);
    end
endmodule

// File: tb/tb_avalon_pio_in_edge.sv
// tb_avalon_pio_in_edge: rising/falling/any-edge PIO instances against a history-based reference model
module tb_avalon_pio_in_edge;
  import pio_in_pkg::*;
  localparam int S = 2;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_port = '0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] rd [3];
  logic        irq_w [3];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    avalon_pio_in_edge_if bus ();
    assign bus.address    = address;
    assign bus.chipselect = chipselect;
    assign bus.write_n    = write_n;
    assign bus.writedata  = writedata;
    assign rd[g]          = bus.readdata;
    assign irq_w[g]       = bus.irq;
    avalon_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(g), .DEBOUNCE_CYCLES(16)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus), .in_port(in_port)
    );
  end

  // reference model: filtered value is the input seen S-1 steps earlier; edges derived from that history
  logic [7:0]  inh [8192];
  int          k = 0, rbase = 0;
  logic [7:0]  f1 = '0, f2 = '0, m_mask = '0;
  logic [7:0]  m_ec [3] = '{default: '0};
  logic [31:0] exp_rd [3] = '{default: '0};
  logic        exp_irq [3] = '{default: 1'b0};

  function automatic logic [7:0] sel(input int t, input logic [7:0] c, input logic [7:0] o);
    return t == EDGE_RISE ? c & ~o : t == EDGE_FALL ? ~c & o : c ^ o;
  endfunction

  task automatic model_reset();
    rbase = k; f1 = '0; f2 = '0; m_mask = '0;
    for (int d = 0; d < 3; d++) begin
      m_ec[d] = '0; exp_rd[d] = '0; exp_irq[d] = 1'b0;
    end
  endtask

  task automatic step(input logic [7:0] din, input logic [1:0] a, input logic cs, input logic we,
                      input logic [31:0] wd);
    int idx;
    @(negedge clk);
    in_port = din; address = a; chipselect = cs; write_n = ~we; writedata = wd;
    @(posedge clk);
    k++; inh[k] = din;
    for (int d = 0; d < 3; d++) begin
      exp_rd[d] = a == ADDR_DATA ? 32'(f1) : a == ADDR_MASK ? 32'(m_mask) : a == ADDR_EDGE ? 32'(m_ec[d]) : 32'h0;
      m_ec[d]   = (m_ec[d] & ~((cs && we && a == ADDR_EDGE) ? wd[7:0] : 8'h0)) | sel(d, f1, f2);
    end
    if (cs && we && a == ADDR_MASK) m_mask = wd[7:0];
    idx = k - S + 1;
    f2 = f1;
    f1 = idx > rbase ? inh[idx] : 8'h0;
    for (int d = 0; d < 3; d++) exp_irq[d] = |(m_ec[d] & m_mask);
    #1;
  endtask

  task automatic test_reset();
    chipselect = 1'b1; write_n = 1'b0; writedata = '1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_port = 8'($urandom); address = 2'(i);
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        n_chk++; if (rd[d] !== 32'h0) begin n_fail++; $display("FAIL reset_rd dut%0d addr %0d: got %h exp 0", d, i % 4, rd[d]); end
        n_chk++; if (irq_w[d] !== 1'b0) begin n_fail++; $display("FAIL reset_irq dut%0d: got %b exp 0", d, irq_w[d]); end
      end
    end
    @(negedge clk);
    in_port = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0; address = '0; reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step(8'h00, 2'(i), 1'b0, 1'b0, 32'h0);
      for (int d = 0; d < 3; d++) begin
        n_chk++; if (rd[d] !== 32'h0) begin n_fail++; $display("FAIL post_reset_rd dut%0d: got %h exp 0", d, rd[d]); end
        n_chk++; if (irq_w[d] !== 1'b0) begin n_fail++; $display("FAIL post_reset_irq dut%0d: got %b exp 0", d, irq_w[d]); end
      end
    end
  endtask

`ifdef PIO_DEBOUNCE_EN
  task automatic test_debounce();
    for (int i = 1; i <= 45; i++) begin
      step(i <= 15 ? 8'h01 : 8'h00, i <= 40 ? ADDR_DATA : ADDR_EDGE, 1'b0, 1'b0, 32'h0);
      n_chk++; if (rd[0] !== 32'h0) begin n_fail++; $display("FAIL glitch step %0d: got %h exp 0", i, rd[0]); end
    end
    for (int i = 1; i <= S + 20; i++) begin
      step(8'h01, ADDR_DATA, 1'b0, 1'b0, 32'h0);
      if (i == S + 17 || i == S + 18) begin
        n_chk++;
        if (rd[0] !== (i == S + 18 ? 32'h1 : 32'h0)) begin
          n_fail++; $display("FAIL debounce_latency step %0d: got %h exp %h", i, rd[0], i == S + 18 ? 32'h1 : 32'h0);
        end
      end
    end
  endtask
`else
  task automatic test_rise_latency();
    for (int i = 1; i <= S + 3; i++) begin
      step(8'h05, ADDR_DATA, 1'b0, 1'b0, 32'h0);
      for (int d = 0; d < 3; d++) begin
        n_chk++; if (rd[d] !== exp_rd[d]) begin n_fail++; $display("FAIL latency_rd dut%0d step %0d: got %h exp %h", d, i, rd[d], exp_rd[d]); end
      end
      n_chk++;
      if (rd[0] !== (i >= S + 1 ? 32'h5 : 32'h0)) begin
        n_fail++; $display("FAIL latency_data step %0d: got %h exp %h", i, rd[0], i >= S + 1 ? 32'h5 : 32'h0);
      end
    end
    step(8'h05, ADDR_EDGE, 1'b0, 1'b0, 32'h0);
    n_chk++; if (rd[0] !== 32'h5) begin n_fail++; $display("FAIL rise_capture: got %h exp 00000005", rd[0]); end
    n_chk++; if (irq_w[0] !== 1'b0) begin n_fail++; $display("FAIL masked_irq: got %b exp 0", irq_w[0]); end
  endtask

  task automatic test_mask_w1c();
    step(8'h05, ADDR_MASK, 1'b1, 1'b1, 32'hABCDEF04);
    n_chk++; if (irq_w[0] !== 1'b1) begin n_fail++; $display("FAIL unmask_irq: got %b exp 1", irq_w[0]); end
    step(8'h05, ADDR_EDGE, 1'b1, 1'b1, 32'hFFFFFF04);
    n_chk++; if (irq_w[0] !== 1'b0) begin n_fail++; $display("FAIL w1c_irq: got %b exp 0", irq_w[0]); end
    step(8'h05, ADDR_EDGE, 1'b0, 1'b0, 32'h0);
    n_chk++; if (rd[0] !== 32'h1) begin n_fail++; $display("FAIL w1c_edge: got %h exp 00000001", rd[0]); end
    step(8'h05, ADDR_MASK, 1'b0, 1'b1, 32'hFF);
    step(8'h05, ADDR_DATA, 1'b1, 1'b1, 32'hFF);
    step(8'h05, ADDR_MASK, 1'b0, 1'b0, 32'h0);
    n_chk++; if (rd[0] !== 32'h4) begin n_fail++; $display("FAIL cs_ignored_mask: got %h exp 00000004", rd[0]); end
    for (int d = 0; d < 3; d++) begin
      n_chk++; if (irq_w[d] !== exp_irq[d]) begin n_fail++; $display("FAIL mask_irq dut%0d: got %b exp %b", d, irq_w[d], exp_irq[d]); end
    end
  endtask

  task automatic test_set_wins();
    repeat (S + 2) step(8'h04, ADDR_EDGE, 1'b0, 1'b0, 32'h0);
    step(8'h04, ADDR_EDGE, 1'b1, 1'b1, 32'h1);
    for (int i = 0; i <= S; i++) step(8'h05, ADDR_EDGE, i == S, i == S, 32'h1);
    step(8'h05, ADDR_EDGE, 1'b0, 1'b0, 32'h0);
    n_chk++; if (rd[0][0] !== 1'b1) begin n_fail++; $display("FAIL set_wins: got %b exp 1", rd[0][0]); end
    for (int d = 0; d < 3; d++) begin
      n_chk++; if (rd[d] !== exp_rd[d]) begin n_fail++; $display("FAIL set_wins_rd dut%0d: got %h exp %h", d, rd[d], exp_rd[d]); end
    end
  endtask

  task automatic test_any_edge();
    step(8'h05, ADDR_EDGE, 1'b1, 1'b1, 32'hFF);
    for (int i = 0; i < 12; i++) begin
      step(i < 5 ? 8'h0D : 8'h05, ADDR_EDGE, i == S + 2, i == S + 2, 32'h08);
      if (i == S + 1 || i == S + 3 || i == S + 6) begin
        n_chk++;
        if (rd[2][3] !== (i != S + 3)) begin
          n_fail++; $display("FAIL any_edge step %0d: got %b exp %b", i, rd[2][3], i != S + 3);
        end
      end
      for (int d = 0; d < 3; d++) begin
        n_chk++; if (rd[d] !== exp_rd[d]) begin n_fail++; $display("FAIL any_edge_rd dut%0d step %0d: got %h exp %h", d, i, rd[d], exp_rd[d]); end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] din = 8'h05;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) din = 8'($urandom);
      step(din, 2'($urandom), 1'($urandom), 1'($urandom), $urandom);
      for (int d = 0; d < 3; d++) begin
        n_chk++; if (rd[d] !== exp_rd[d]) begin n_fail++; $display("FAIL rand_rd dut%0d step %0d: got %h exp %h", d, i, rd[d], exp_rd[d]); end
        n_chk++; if (irq_w[d] !== exp_irq[d]) begin n_fail++; $display("FAIL rand_irq dut%0d step %0d: got %b exp %b", d, i, irq_w[d], exp_irq[d]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    repeat (S + 1) step(8'h00, ADDR_MASK, 1'b1, 1'b1, 32'hFF);
    repeat (S + 2) step(8'hFF, ADDR_EDGE, 1'b0, 1'b0, 32'h0);
    n_chk++; if (irq_w[0] !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %b exp 1", irq_w[0]); end
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_chk++; if (irq_w[d] !== 1'b0) begin n_fail++; $display("FAIL async_reset_irq dut%0d: got %b exp 0", d, irq_w[d]); end
      n_chk++; if (rd[d] !== 32'h0) begin n_fail++; $display("FAIL async_reset_rd dut%0d: got %h exp 0", d, rd[d]); end
    end
    in_port = '0; chipselect = 1'b0; write_n = 1'b1; address = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      step(8'(i * 3), 2'(i), 1'b0, 1'b0, 32'h0);
      for (int d = 0; d < 3; d++) begin
        n_chk++; if (rd[d] !== exp_rd[d]) begin n_fail++; $display("FAIL after_reset_rd dut%0d step %0d: got %h exp %h", d, i, rd[d], exp_rd[d]); end
        n_chk++; if (irq_w[d] !== exp_irq[d]) begin n_fail++; $display("FAIL after_reset_irq dut%0d: got %b exp %b", d, irq_w[d], exp_irq[d]); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef PIO_DEBOUNCE_EN
    test_debounce();
`else
    test_rise_latency();
    test_mask_w1c();
    test_set_wins();
    test_any_edge();
    test_random();
    test_reset_mid();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
